tone_frame_buffer: RTL and testbench

- Frame buffer that acts as the memory responder for the global tone-mapping engine.
- Accepts a frame of raw radiance pixels over a ready/valid input stream and records their min and max.
- Starts the engine, serves its single-port read/write memory interface until it reports finish, then streams the tone-mapped frame out over a ready/valid output stream.

---
 rtl/tone_frame_buffer.sv | 190 +++++++++++++++++++
 tb/tb_tone_frame_buffer.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tone_frame_buffer.sv
// Frame buffer acting as the memory responder for the global tone-mapping
// engine. Loads one raw frame and tracks its min/max. Kicks the engine and
// serves its single-port memory until the engine reports finish. Then it
// streams the low d_hw bits of every stored word out in address order.
//
// Stream handshakes (input and output) follow strict valid/ready semantics.
// A beat transfers on a rising edge where valid and ready are both high.
// A producer holding valid keeps data/last stable until that transfer, and
// valid never waits on ready.
module tone_frame_buffer #(
    parameter int d_w    = 16,
    parameter int d_hw   = 8,
    parameter int addr_w = 10,
    parameter int num_w  = 11
) (
    input  logic              i_clk,
    input  logic              rst,
    input  logic              i_frame_start,
    input  logic [num_w-1:0]  i_frame_pixels,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [d_w-1:0]    i_in_data,
    output logic [num_w-1:0]  o_total_pixels,
    output logic [d_w-1:0]    o_rad_min,
    output logic [d_w-1:0]    o_rad_maxmin,
    output logic              o_start,
    input  logic [addr_w-1:0] i_addr,
    input  logic              i_wen,
    input  logic [d_w-1:0]    i_wdata,
    output logic [d_w-1:0]    o_rdata,
    input  logic              i_fin,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [d_hw-1:0]   o_out_data,
    output logic              o_out_last,
    output logic              o_busy,
    output logic              o_done,
    output logic [2:0]        o_state
);

    localparam int depth = 2 ** addr_w;
    localparam logic [num_w-1:0] depth_n = num_w'(depth);
    localparam logic [num_w-1:0] one_n   = num_w'(1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        PROC  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t state, state_nxt;

    // Frame storage; contents survive reset.
    logic [d_w-1:0] mem [depth];

    logic [num_w-1:0] n_q;
    logic [num_w-1:0] wptr;
    logic [num_w-1:0] rptr;
    logic [d_w-1:0]   min_q;
    logic [d_w-1:0]   max_q;

    logic           start_ok;
    logic           in_hs;
    logic           load_last;
    logic           out_hs;
    logic           drain_end;
    logic           wr_ok;
    logic [d_w-1:0] pix_min;
    logic [d_w-1:0] pix_max;

    // A frame is accepted only in IDLE and only for a count in 1..depth.
    assign start_ok  = i_frame_start && (i_frame_pixels != '0) && (i_frame_pixels <= depth_n);
    assign in_hs     = (state == LOAD) && i_in_valid;
    assign load_last = in_hs && (wptr == n_q - one_n);
    assign out_hs    = (state == DRAIN) && o_out_valid && i_out_ready;
    assign drain_end = out_hs && o_out_last;
    // Engine writes beyond the loaded frame are dropped.
    assign wr_ok     = (state == PROC) && i_wen && (num_w'(i_addr) < n_q);

    // Running extremes including the pixel being accepted this cycle.
    assign pix_min = (i_in_data < min_q) ? i_in_data : min_q;
    assign pix_max = (i_in_data > max_q) ? i_in_data : max_q;

    assign o_in_ready = (state == LOAD);
    assign o_busy     = (state != IDLE);
    assign o_done     = (state == DONE);
    assign o_state    = state;
    // Zero-latency engine read; a same-edge write is seen only next cycle.
    assign o_rdata    = (state == PROC) ? mem[i_addr] : '0;

    // State register.
    always_ff @(posedge i_clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state selection.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_ok)  state_nxt = LOAD;
            LOAD:    if (load_last) state_nxt = PROC;
            PROC:    if (i_fin)     state_nxt = DRAIN;
            DRAIN:   if (drain_end) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Memory write port: pixel stream during LOAD, engine during PROC.
    always_ff @(posedge i_clk) begin
        if (in_hs) begin
            mem[wptr[addr_w-1:0]] <= i_in_data;
        end else if (wr_ok) begin
            mem[i_addr] <= i_wdata;
        end
    end

    // Frame bookkeeping, statistics and the registered output stream.
    always_ff @(posedge i_clk or posedge rst) begin
        if (rst) begin
            n_q            <= '0;
            wptr           <= '0;
            rptr           <= '0;
            min_q          <= '1;
            max_q          <= '0;
            o_total_pixels <= '0;
            o_rad_min      <= '0;
            o_rad_maxmin   <= d_w'(1);
            o_start        <= 1'b0;
            o_out_valid    <= 1'b0;
            o_out_data     <= '0;
            o_out_last     <= 1'b0;
        end else begin
            // Start pulse lands in the first PROC cycle only.
            o_start <= load_last;
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        n_q            <= i_frame_pixels;
                        o_total_pixels <= i_frame_pixels;
                        min_q          <= '1;
                        max_q          <= '0;
                        wptr           <= '0;
                    end
                end
                LOAD: begin
                    if (in_hs) begin
                        min_q <= pix_min;
                        max_q <= pix_max;
                        wptr  <= wptr + one_n;
                        if (load_last) begin
                            o_rad_min    <= pix_min;
                            o_rad_maxmin <= (pix_max == pix_min) ? d_w'(1) : (pix_max - pix_min);
                        end
                    end
                end
                PROC: begin
                    if (i_fin) begin
                        // Prefetch word 0 so valid is up in the first DRAIN cycle.
                        o_out_valid <= 1'b1;
                        o_out_data  <= mem[{addr_w{1'b0}}][d_hw-1:0];
                        o_out_last  <= (n_q == one_n);
                        rptr        <= one_n;
                    end
                end
                DRAIN: begin
                    if (out_hs) begin
                        if (o_out_last) begin
                            o_out_valid <= 1'b0;
                            o_out_last  <= 1'b0;
                        end else begin
                            o_out_data <= mem[rptr[addr_w-1:0]][d_hw-1:0];
                            o_out_last <= (rptr == n_q - one_n);
                            rptr       <= rptr + one_n;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tone_frame_buffer.sv
// Testbench for tone_frame_buffer: directed frames from the test plan plus
// randomized frames, checked against a frame-level memory model.
module tb_tone_frame_buffer;

    localparam int d_w    = 16;
    localparam int d_hw   = 8;
    localparam int addr_w = 10;
    localparam int num_w  = 11;
    localparam int depth  = 1024;

    logic              i_clk = 1'b0;
    logic              rst;
    logic              i_frame_start;
    logic [num_w-1:0]  i_frame_pixels;
    logic              i_in_valid;
    logic              o_in_ready;
    logic [d_w-1:0]    i_in_data;
    logic [num_w-1:0]  o_total_pixels;
    logic [d_w-1:0]    o_rad_min;
    logic [d_w-1:0]    o_rad_maxmin;
    logic              o_start;
    logic [addr_w-1:0] i_addr;
    logic              i_wen;
    logic [d_w-1:0]    i_wdata;
    logic [d_w-1:0]    o_rdata;
    logic              i_fin;
    logic              o_out_valid;
    logic              i_out_ready;
    logic [d_hw-1:0]   o_out_data;
    logic              o_out_last;
    logic              o_busy;
    logic              o_done;
    logic [2:0]        o_state;

    tone_frame_buffer #(
        .d_w(d_w), .d_hw(d_hw), .addr_w(addr_w), .num_w(num_w)
    ) dut (
        .i_clk(i_clk), .rst(rst),
        .i_frame_start(i_frame_start), .i_frame_pixels(i_frame_pixels),
        .i_in_valid(i_in_valid), .o_in_ready(o_in_ready), .i_in_data(i_in_data),
        .o_total_pixels(o_total_pixels), .o_rad_min(o_rad_min), .o_rad_maxmin(o_rad_maxmin),
        .o_start(o_start), .i_addr(i_addr), .i_wen(i_wen), .i_wdata(i_wdata),
        .o_rdata(o_rdata), .i_fin(i_fin),
        .o_out_valid(o_out_valid), .i_out_ready(i_out_ready), .o_out_data(o_out_data),
        .o_out_last(o_out_last), .o_busy(o_busy), .o_done(o_done), .o_state(o_state)
    );

    // Clock generation.
    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int last_total;

    logic [d_w-1:0]  ref_mem [depth];
    bit              known   [depth];
    logic [d_w-1:0]  pix     [$];
    bit              rdy_pat [$];
    logic [d_hw-1:0] exp_q   [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // All tasks start and end just after a falling edge.
    task automatic start_frame(input int n);
        i_frame_start  = 1'b1;
        i_frame_pixels = num_w'(n);
        @(posedge i_clk);
        @(negedge i_clk);
        i_frame_start = 1'b0;
        check("start_busy", o_busy, 1);
        check("start_ready", o_in_ready, 1);
        last_total = n;
    endtask

    task automatic bad_start(input int n);
        i_frame_start  = 1'b1;
        i_frame_pixels = num_w'(n);
        @(posedge i_clk);
        @(negedge i_clk);
        i_frame_start = 1'b0;
        check("bad_start_busy", o_busy, 0);
        check("bad_start_ready", o_in_ready, 0);
        check("bad_start_total", o_total_pixels, last_total);
    endtask

    task automatic load_pixels(input int cnt, input bit gaps);
        for (int i = 0; i < cnt; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    i_in_valid = 1'b0;
                    @(posedge i_clk);
                    @(negedge i_clk);
                end
            end
            i_in_valid = 1'b1;
            i_in_data  = pix[i];
            @(posedge i_clk);
            ref_mem[i] = pix[i];
            known[i]   = 1'b1;
            @(negedge i_clk);
            if (i < cnt - 1) check("no_early_start", o_start, 0);
        end
        i_in_valid = 1'b0;
    endtask

    task automatic check_load_result(input int n);
        logic [d_w-1:0] mn;
        logic [d_w-1:0] mx;
        mn = pix[0];
        mx = pix[0];
        for (int i = 1; i < n; i++) begin
            if (pix[i] < mn) mn = pix[i];
            if (pix[i] > mx) mx = pix[i];
        end
        check("start_pulse", o_start, 1);
        check("proc_ready", o_in_ready, 0);
        check("proc_busy", o_busy, 1);
        check("rad_min", o_rad_min, mn);
        check("rad_maxmin", o_rad_maxmin, (mx == mn) ? 1 : (mx - mn));
        check("total", o_total_pixels, n);
    endtask

    task automatic eng_op(input int addr, input bit wen, input logic [d_w-1:0] wd, input int n);
        i_addr  = addr_w'(addr);
        i_wen   = wen;
        i_wdata = wd;
        #1;
        if (known[addr]) check("rdata", o_rdata, ref_mem[addr]);
        @(posedge i_clk);
        if (wen && addr < n) begin
            ref_mem[addr] = wd;
            known[addr]   = 1'b1;
        end
        @(negedge i_clk);
        i_wen = 1'b0;
    endtask

    task automatic run_proc_random(input int n, input int ops);
        int hi;
        hi = (n + 3 > depth - 1) ? depth - 1 : n + 3;
        for (int k = 0; k < ops; k++) begin
            eng_op($urandom_range(0, hi), bit'($urandom_range(0, 1)), d_w'($urandom), n);
            if (k == 0) check("start_once", o_start, 0);
        end
    endtask

    task automatic finish_proc();
        i_wen = 1'b0;
        i_fin = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        i_fin = 1'b0;
    endtask

    task automatic drain(input int n);
        int guard;
        guard = 0;
        exp_q.delete();
        for (int i = 0; i < n; i++) exp_q.push_back(ref_mem[i][d_hw-1:0]);
        while (exp_q.size() > 0 && guard < 20 * n + 100) begin
            bit r;
            if (rdy_pat.size() > 0) r = rdy_pat.pop_front();
            else r = ($urandom_range(0, 2) != 0);
            i_out_ready = r;
            #1;
            check("out_valid", o_out_valid, 1);
            check("out_data", o_out_data, exp_q[0]);
            check("out_last", o_out_last, exp_q.size() == 1);
            @(posedge i_clk);
            if (r) void'(exp_q.pop_front());
            @(negedge i_clk);
            guard++;
        end
        check("drain_timeout", exp_q.size(), 0);
        i_out_ready = 1'b0;
        #1;
        check("done_pulse", o_done, 1);
        check("valid_drop", o_out_valid, 0);
        check("last_drop", o_out_last, 0);
        @(posedge i_clk);
        @(negedge i_clk);
        check("done_clear", o_done, 0);
        check("back_idle", o_busy, 0);
    endtask

    task automatic run_frame(input int n, input bit gaps, input int ops);
        pix.delete();
        for (int i = 0; i < n; i++) pix.push_back(d_w'($urandom));
        start_frame(n);
        load_pixels(n, gaps);
        check_load_result(n);
        run_proc_random(n, ops);
        finish_proc();
        drain(n);
    endtask

    // Watchdog against a stuck run.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Directed and randomized stimulus.
    initial begin
        rst            = 1'b1;
        i_frame_start  = 1'b0;
        i_frame_pixels = '0;
        i_in_valid     = 1'b0;
        i_in_data      = '0;
        i_addr         = '0;
        i_wen          = 1'b0;
        i_wdata        = '0;
        i_fin          = 1'b0;
        i_out_ready    = 1'b0;
        last_total     = 0;

        @(negedge i_clk);
        check("rst_busy", o_busy, 0);
        check("rst_in_ready", o_in_ready, 0);
        check("rst_start", o_start, 0);
        check("rst_valid", o_out_valid, 0);
        check("rst_data", o_out_data, 0);
        check("rst_last", o_out_last, 0);
        check("rst_done", o_done, 0);
        check("rst_min", o_rad_min, 0);
        check("rst_maxmin", o_rad_maxmin, 1);
        check("rst_total", o_total_pixels, 0);
        check("rst_rdata", o_rdata, 0);
        rst = 1'b0;
        @(negedge i_clk);

        // Out-of-range frame counts are ignored.
        bad_start(0);
        bad_start(1025);

        // Prime memory so the dropped write below has a known old value.
        run_frame(8, 1, 6);

        // Frame A: statistics, engine port, dropped write.
        pix = '{16'd100, 16'd40, 16'd250, 16'd40};
        start_frame(4);
        load_pixels(4, 1);
        check_load_result(4);
        check("A_min", o_rad_min, 40);
        check("A_maxmin", o_rad_maxmin, 210);
        eng_op(2, 1'b0, '0, 4);
        check("A_start_once", o_start, 0);
        eng_op(1, 1'b1, 16'h00C8, 4);
        eng_op(1, 1'b0, '0, 4);
        eng_op(5, 1'b1, 16'hBEEF, 4);
        eng_op(5, 1'b0, '0, 4);
        finish_proc();
        drain(4);

        // Frame B: start ignored in PROC, scripted ready pattern.
        pix = '{16'd10, 16'd20, 16'd30, 16'h01FF};
        start_frame(4);
        load_pixels(4, 0);
        check_load_result(4);
        i_frame_start  = 1'b1;
        i_frame_pixels = num_w'(2);
        @(posedge i_clk);
        @(negedge i_clk);
        i_frame_start = 1'b0;
        check("B_total_kept", o_total_pixels, 4);
        check("B_busy", o_busy, 1);
        check("B_in_ready", o_in_ready, 0);
        check("B_no_valid", o_out_valid, 0);
        check("B_start_once", o_start, 0);
        finish_proc();
        rdy_pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        drain(4);

        // Asynchronous reset in the middle of LOAD.
        pix.delete();
        for (int i = 0; i < 8; i++) pix.push_back(d_w'($urandom));
        start_frame(8);
        load_pixels(3, 0);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_busy", o_busy, 0);
        check("mid_rst_ready", o_in_ready, 0);
        check("mid_rst_maxmin", o_rad_maxmin, 1);
        check("mid_rst_min", o_rad_min, 0);
        check("mid_rst_total", o_total_pixels, 0);
        @(negedge i_clk);
        rst = 1'b0;
        last_total = 0;
        @(negedge i_clk);

        // Flat frame.
        pix = '{16'd77, 16'd77, 16'd77};
        start_frame(3);
        load_pixels(3, 1);
        check_load_result(3);
        check("flat_min", o_rad_min, 77);
        check("flat_maxmin", o_rad_maxmin, 1);
        run_proc_random(3, 4);
        finish_proc();
        drain(3);
        bad_start(0);

        // Randomized frames including both size boundaries.
        run_frame(1, 1, 3);
        for (int f = 0; f < 3; f++) run_frame($urandom_range(2, 40), 1, 8);
        run_frame(1024, 0, 10);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
